// File: rtl/digital_capture_handler.sv
// Periodic logic-input sampler. A START command loads a 16-bit clock divider
// and enables capture. Every DIVIDER clocks, one synchronized byte of
// dc_signal_in is sampled and handed to the upload channel via a
// valid/ready handshake. A STOP command halts sampling, and bytes that are
// already pending still drain.
module digital_capture_handler #(
  parameter logic [7:0] CMD_DC_START = 8'h0B,
  parameter logic [7:0] CMD_DC_STOP  = 8'h0C
) (
  input  logic       clk,
  input  logic       rst_n,          // synchronous, active-high (legacy name)
  input  logic [7:0] dc_signal_in,
  input  logic       cmd_start,
  input  logic       cmd_done,
  input  logic [7:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       upload_req,
  output logic [7:0] upload_data,
  output logic       upload_valid,
  input  logic       upload_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } upload_state_t;

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic          r_start_pending;
  logic          r_stop_pending;
  logic [7:0]    r_div_hi;
  logic [15:0]   r_divider;
  logic          r_capture;
  logic [15:0]   r_counter;
  logic [7:0]    r_sample_reg;
  logic          r_new_sample_flag;
  logic [7:0]    r_upload_data;
  upload_state_t r_upload_state;
  upload_state_t w_upload_state_nxt;

  logic          w_cmd_ctl;
  logic [15:0]   w_div_eff;
  logic          w_tick;
  logic          w_load;

  // A command completes on this cycle. It reloads or stops the sampler and
  // takes priority over a sample tick.
  assign w_cmd_ctl = cmd_done && (r_start_pending || r_stop_pending);
  assign w_div_eff = (r_divider == '0) ? 16'd1 : r_divider;
  assign w_tick    = r_capture && !w_cmd_ctl && (r_counter == (w_div_eff - 16'd1));

  // Two-flop synchronizer on the asynchronous logic inputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= dc_signal_in;
      r_sync2 <= r_sync1;
    end
  end

  // Command decode.
  // The divider high byte is staged and the full divider is committed at
  // cmd_done, so a running capture never sees a half-updated divider.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_start_pending <= 1'b0;
      r_stop_pending  <= 1'b0;
      r_div_hi        <= '0;
      r_divider       <= 16'd1;
      r_capture       <= 1'b0;
    end else begin
      if (cmd_done) begin
        if (r_start_pending) begin
          r_divider <= {r_div_hi, cmd_data};
          r_capture <= 1'b1;
        end else if (r_stop_pending) begin
          r_capture <= 1'b0;
        end
        r_start_pending <= 1'b0;
        r_stop_pending  <= 1'b0;
      end
      if (cmd_start) begin
        r_start_pending <= (cmd_type == CMD_DC_START);
        r_stop_pending  <= (cmd_type == CMD_DC_STOP);
        if (cmd_type == CMD_DC_START) r_div_hi <= cmd_data;
      end
    end
  end

  // Sample-period counter. It restarts on every START or STOP completion.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_counter <= '0;
    end else if (w_cmd_ctl) begin
      r_counter <= '0;
    end else if (r_capture) begin
      r_counter <= w_tick ? '0 : r_counter + 16'd1;
    end
  end

  // Sample latch and pending flag.
  // A new tick wins over the upload FSM clearing the flag in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sample_reg      <= '0;
      r_new_sample_flag <= 1'b0;
    end else if (w_tick) begin
      r_sample_reg      <= r_sync2;
      r_new_sample_flag <= 1'b1;
    end else if (w_load) begin
      r_new_sample_flag <= 1'b0;
    end
  end

  // Upload FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) r_upload_state <= ST_IDLE;
    else       r_upload_state <= w_upload_state_nxt;
  end

  // Upload FSM next state and load strobe.
  always_comb begin
    w_upload_state_nxt = r_upload_state;
    w_load             = 1'b0;
    unique case (r_upload_state)
      ST_IDLE: begin
        if (r_new_sample_flag) begin
          w_load             = 1'b1;
          w_upload_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (upload_ready) w_upload_state_nxt = ST_IDLE;
      end
      default: w_upload_state_nxt = ST_IDLE;
    endcase
  end

  // Output data holding register. It stays stable for the whole SEND phase.
  always_ff @(posedge clk) begin
    if (rst_n)       r_upload_data <= '0;
    else if (w_load) r_upload_data <= r_sample_reg;
  end

  assign upload_req   = (r_upload_state == ST_SEND);
  assign upload_valid = (r_upload_state == ST_SEND);
  assign upload_data  = r_upload_data;

endmodule

// File: tb/tb_digital_capture_handler.sv
// Self-checking bench for digital_capture_handler. A transaction-level
// reference model predicts sample ticks from absolute clock counts, tracks
// the single pending-sample slot and the output slot, and compares the
// result with the DUT every cycle.
module tb_digital_capture_handler;

  localparam logic [7:0] START = 8'h0B;
  localparam logic [7:0] STOP  = 8'h0C;

  logic       clk;
  logic       rst_n;
  logic [7:0] dc_in;
  logic       cmd_start;
  logic       cmd_done;
  logic [7:0] cmd_type;
  logic [7:0] cmd_data;
  logic       upload_req;
  logic [7:0] upload_data;
  logic       upload_valid;
  logic       upload_ready;

  int n_checks;
  int n_errors;
  int dut_acc;

  // Reference model state.
  longint     m_edge;
  longint     m_next_tick;
  bit         m_capture;
  logic [15:0] m_div;
  logic [7:0] m_div_hi;
  bit         m_start_p;
  bit         m_stop_p;
  logic [7:0] m_prev1;
  logic [7:0] m_prev2;
  bit         m_has_pend;
  logic [7:0] m_pend;
  bit         m_sending;
  logic [7:0] m_out;

  digital_capture_handler #(
    .CMD_DC_START(START),
    .CMD_DC_STOP (STOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dc_signal_in(dc_in),
    .cmd_start   (cmd_start),
    .cmd_done    (cmd_done),
    .cmd_type    (cmd_type),
    .cmd_data    (cmd_data),
    .upload_req  (upload_req),
    .upload_data (upload_data),
    .upload_valid(upload_valid),
    .upload_ready(upload_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 64'd1 : longint'(d);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    bit         ctl;
    bit         tk;
    logic [7:0] sampled;
    m_edge++;
    if (rst_n) begin
      m_capture  = 0; m_div = 16'd1; m_div_hi = '0;
      m_start_p  = 0; m_stop_p = 0;
      m_prev1    = '0; m_prev2 = '0;
      m_has_pend = 0; m_pend = '0;
      m_sending  = 0; m_out = '0;
      return;
    end
    ctl     = cmd_done && (m_start_p || m_stop_p);
    tk      = m_capture && !ctl && (m_edge == m_next_tick);
    sampled = m_prev2;
    m_prev2 = m_prev1;
    m_prev1 = dc_in;
    if (tk) m_next_tick = m_next_tick + eff_div(m_div);
    if (ctl) begin
      if (m_start_p) begin
        m_div       = {m_div_hi, cmd_data};
        m_capture   = 1;
        m_next_tick = m_edge + eff_div(m_div);
      end else begin
        m_capture = 0;
      end
    end
    if (cmd_done) begin m_start_p = 0; m_stop_p = 0; end
    if (cmd_start) begin
      m_start_p = (cmd_type == START);
      m_stop_p  = (cmd_type == STOP);
      if (cmd_type == START) m_div_hi = cmd_data;
    end
    // Output slot: accept a byte, or pull the pending sample into it.
    if (m_sending && upload_ready) m_sending = 0;
    else if (!m_sending && m_has_pend) begin
      m_out = m_pend; m_sending = 1; m_has_pend = 0;
    end
    // Newest sample overwrites any older pending one.
    if (tk) begin m_pend = sampled; m_has_pend = 1; end
  endfunction

  task automatic step();
    model_edge();
    if (upload_valid && upload_ready) dut_acc++;
    @(posedge clk);
    #1;
    chk("req",   16'(upload_req),             16'(m_sending));
    chk("valid", 16'(upload_valid),           16'(m_sending));
    chk("data",  16'(upload_data),            16'(m_out));
    chk("flag",  16'(dut.r_new_sample_flag),  16'(m_has_pend));
    chk("state", 16'(dut.r_upload_state),     16'(m_sending));
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic send_cmd(input logic [7:0] typ, input logic [7:0] hi, input logic [7:0] lo);
    cmd_start = 1'b1; cmd_type = typ; cmd_data = hi;
    step();
    cmd_start = 1'b0; cmd_done = 1'b1; cmd_data = lo;
    step();
    cmd_done = 1'b0; cmd_type = '0; cmd_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    steps(2);
    rst_n = 1'b0;
    dut_acc = 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; dut_acc = 0; m_edge = 0; m_next_tick = 0;
    rst_n = 1'b1; dc_in = '0; cmd_start = 1'b0; cmd_done = 1'b0;
    cmd_type = '0; cmd_data = '0; upload_ready = 1'b1;
    #2;

    // Reset state.
    do_reset();
    chk("rst_req",  16'(upload_req),   16'h0);
    chk("rst_data", 16'(upload_data),  16'h0);
    steps(10);

    // Divider 0x1770, ready high, slowly stepping input: one byte per 6000 clk.
    do_reset();
    upload_ready = 1'b1;
    dc_in = 8'h10;
    send_cmd(START, 8'h17, 8'h70);
    for (int unsigned i = 0; i < 6 * 6000 + 20; i++) begin
      if (i % 600 == 0) dc_in = dc_in + 8'd1;
      step();
    end
    chk("div6000_count", 16'(dut_acc), 16'd6);

    // Divider 1, constant 0xA5: a byte every other cycle.
    do_reset();
    dc_in = 8'hA5;
    send_cmd(START, 8'h00, 8'h01);
    dut_acc = 0;
    steps(41);
    chk("div1_data", 16'(upload_data), 16'h00A5);
    send_cmd(STOP, 8'h00, 8'h00);
    steps(6);
    chk("div1_drain_flag",  16'(dut.r_new_sample_flag), 16'h0);
    chk("div1_drain_valid", 16'(upload_valid),          16'h0);

    // Divider 100, ready stalled for 1000 cycles while the input keeps moving.
    do_reset();
    upload_ready = 1'b0;
    send_cmd(START, 8'h00, 8'd100);
    for (int unsigned i = 0; i < 1000; i++) begin
      dc_in = 8'($urandom);
      step();
    end
    upload_ready = 1'b1;
    steps(300);

    // START then STOP after exactly three ticks at divider 5.
    do_reset();
    upload_ready = 1'b1;
    send_cmd(START, 8'h00, 8'd5);
    for (int unsigned i = 0; i < 15; i++) begin
      dc_in = 8'($urandom);
      step();
    end
    send_cmd(STOP, 8'h00, 8'h00);
    steps(100);
    chk("stop_count", 16'(dut_acc),    16'd3);
    chk("stop_req",   16'(upload_req), 16'h0);

    // Reset asserted while a byte is stuck in SEND.
    do_reset();
    upload_ready = 1'b0;
    dc_in = 8'h3C;
    send_cmd(START, 8'h00, 8'd3);
    steps(10);
    chk("pre_rst_valid", 16'(upload_valid), 16'h1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("midrst_req",   16'(upload_req),              16'h0);
    chk("midrst_valid", 16'(upload_valid),            16'h0);
    chk("midrst_state", 16'(dut.r_upload_state),      16'h0);
    chk("midrst_flag",  16'(dut.r_new_sample_flag),   16'h0);
    upload_ready = 1'b1;
    steps(10);

    // Divider 0 behaves as 1; an unknown opcode mid-run changes nothing.
    do_reset();
    send_cmd(START, 8'h00, 8'h00);
    for (int unsigned i = 0; i < 20; i++) begin
      dc_in = 8'($urandom);
      step();
    end
    send_cmd(8'h55, 8'hFF, 8'hFF);
    for (int unsigned i = 0; i < 20; i++) begin
      dc_in = 8'($urandom);
      step();
    end

    // Random traffic: divider reloads while running, bursty ready.
    do_reset();
    for (int unsigned r = 0; r < 5; r++) begin
      send_cmd(START, 8'h00, 8'($urandom_range(0, 6)));
      for (int unsigned i = 0; i < 400; i++) begin
        dc_in        = 8'($urandom);
        upload_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    send_cmd(STOP, 8'h00, 8'h00);
    upload_ready = 1'b1;
    steps(20);
    chk("final_idle", 16'(upload_valid), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
